// File: rtl/trace_latency_matcher.sv
// trace_latency_matcher: pairs each core output handshake with the oldest outstanding
// input handshake and emits a trace record holding the transaction ID, the ingress
// timestamp, the latency in cycles and the captured output data.
//
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   in_fire         - core input handshake completed this cycle
//   out_fire        - core output handshake completed this cycle
//   out_data        - core output data, sampled with out_fire
//   trace_valid     - trace record held in the output register
//   trace_ready     - consumer accepts the record
//   trace_id/t_in/latency/data - record fields
//   drop_cnt        - saturating count of records lost to a busy trace output
//   overflow        - sticky: in_fire while the timestamp FIFO was full
//   underflow       - sticky: out_fire with no matching ingress entry
module trace_latency_matcher #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ID_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_fire,
  input  logic                  out_fire,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [ID_WIDTH-1:0]   trace_id,
  output logic [TS_WIDTH-1:0]   trace_t_in,
  output logic [TS_WIDTH-1:0]   trace_latency,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic [31:0]           drop_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [TS_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [ID_WIDTH-1:0]   next_id_q, next_id_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ID_WIDTH-1:0]   id_mem_q [DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem_q [DEPTH];

  logic                  tv_q, tv_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [TS_WIDTH-1:0]   tt_q, tt_d;
  logic [TS_WIDTH-1:0]   tl_q, tl_d;
  logic [DATA_WIDTH-1:0] td_q, td_d;
  logic [31:0]           drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  fifo_empty, fifo_full;
  logic                  bypass, pop, push;
  logic                  rec_valid;
  logic [ID_WIDTH-1:0]   rec_id;
  logic [TS_WIDTH-1:0]   rec_t_in;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    // Zero-latency core: pair the handshakes directly without touching the FIFO.
    bypass     = in_fire && out_fire && fifo_empty;
    pop        = out_fire && !fifo_empty;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    push       = in_fire && !bypass && (!fifo_full || pop);

    rec_valid  = pop || bypass;
    rec_id     = bypass ? next_id_q : id_mem_q[rd_ptr_q];
    rec_t_in   = bypass ? cycle_cnt_q : ts_mem_q[rd_ptr_q];

    cycle_cnt_d = cycle_cnt_q + 1'b1;
    next_id_d   = in_fire ? next_id_q + 1'b1 : next_id_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;

    ovf_d = ovf_q || (in_fire && fifo_full && !pop);
    unf_d = unf_q || (out_fire && fifo_empty && !in_fire);

    tv_d   = tv_q;
    tid_d  = tid_q;
    tt_d   = tt_q;
    tl_d   = tl_q;
    td_d   = td_q;
    drop_d = drop_q;
    if (rec_valid) begin
      if (!tv_q || trace_ready) begin
        tv_d  = 1'b1;
        tid_d = rec_id;
        tt_d  = rec_t_in;
        tl_d  = cycle_cnt_q - rec_t_in;
        td_d  = out_data;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (tv_q && trace_ready) begin
      tv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      next_id_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tv_q        <= 1'b0;
      tid_q       <= '0;
      tt_q        <= '0;
      tl_q        <= '0;
      td_q        <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      next_id_q   <= next_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tv_q        <= tv_d;
      tid_q       <= tid_d;
      tt_q        <= tt_d;
      tl_q        <= tl_d;
      td_q        <= td_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= next_id_q;
      ts_mem_q[wr_ptr_q] <= cycle_cnt_q;
    end
  end

  assign trace_valid   = tv_q;
  assign trace_id      = tid_q;
  assign trace_t_in    = tt_q;
  assign trace_latency = tl_q;
  assign trace_data    = td_q;
  assign drop_cnt      = drop_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: doc/trace_latency_matcher.md
TRACE_LATENCY_MATCHER -- requirements
Module: trace_latency_matcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of the monitored core output data.
REQ-002 SHALL have parameter TS_WIDTH, default 32: width of the cycle timestamp and latency fields.
REQ-003 SHALL have parameter DEPTH, default 16, a power of 2 >= 2: number of in-flight ingress timestamps held.
REQ-004 SHALL have parameter ID_WIDTH, default 16: width of the transaction ID.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_fire  input  1  core input handshake completed this cycle (in_valid && in_ready).
REQ-008 SHALL have port out_fire  input  1  core output handshake completed this cycle (out_valid && out_ready).
REQ-009 SHALL have port out_data  input  DATA_WIDTH  core output data, sampled when out_fire=1.
REQ-010 SHALL have port trace_valid  output  1  trace record available.
REQ-011 SHALL have port trace_ready  input  1  trace consumer accepts record.
REQ-012 SHALL have port trace_id  output  ID_WIDTH  transaction ID of the record.
REQ-013 SHALL have port trace_t_in  output  TS_WIDTH  ingress timestamp.
REQ-014 SHALL have port trace_latency  output  TS_WIDTH  egress minus ingress cycle count.
REQ-015 SHALL have port trace_data  output  DATA_WIDTH  captured out_data.
REQ-016 SHALL have port drop_cnt  output  32  records lost because the trace output was occupied.
REQ-017 SHALL have port overflow  output  1  sticky: in_fire seen while timestamp FIFO full.
REQ-018 SHALL have port underflow  output  1  sticky: out_fire seen with no matching ingress entry.

Function
REQ-019 SHALL keep a free-running counter cycle_cnt (TS_WIDTH), +1 every cycle, wrapping from all-ones to 0.
REQ-020 SHALL keep next_id (ID_WIDTH), +1 on every in_fire including overflowed ones, wrapping modulo 2^ID_WIDTH.
REQ-021 On in_fire with the FIFO not full (after any same-cycle pop), SHALL push {next_id, cycle_cnt}.
REQ-022 On in_fire with the FIFO full and no same-cycle pop, SHALL discard the entry and set overflow.
REQ-023 On out_fire with the FIFO non-empty, SHALL pop the head and form a record {id, t_in, latency = cycle_cnt - t_in mod 2^TS_WIDTH, out_data}.
REQ-024 On same-cycle in_fire and out_fire with the FIFO empty (zero-latency core), SHALL bypass the FIFO: record id = next_id, t_in = cycle_cnt, latency = 0; nothing pushed.
REQ-025 On out_fire with the FIFO empty and no bypass, SHALL set underflow and produce no record.
REQ-026 On same-cycle push and pop with the FIFO full, both SHALL succeed and occupancy SHALL be unchanged.
REQ-027 A formed record SHALL appear on trace_* with trace_valid=1 the cycle after out_fire (1-cycle latency).
REQ-028 The trace output SHALL be a single register; trace_valid SHALL hold, and trace_* SHALL stay stable, until trace_valid && trace_ready.
REQ-029 If a record forms while trace_valid=1 and trace_ready=0, the new record SHALL be dropped and drop_cnt incremented, saturating at 2^32-1.
REQ-030 If a record forms in the same cycle as trace_valid && trace_ready, the new record SHALL be loaded with no drop.
REQ-031 FIFO ordering SHALL be strict FIFO; out_fire pairs with the oldest outstanding in_fire.

Reset
REQ-032 When rst_n=0, SHALL asynchronously clear cycle_cnt, next_id, FIFO pointers/occupancy, trace_valid, trace_* fields, drop_cnt, overflow and underflow to 0.
REQ-033 Reset mid-operation SHALL discard all in-flight entries and any pending record; the first in_fire after reset SHALL get id 0.

Verification
REQ-034 in_fire at cycle_cnt=10, out_fire at 13 with out_data=0xAB, trace_ready=1 -> at 14: trace_valid=1, id=0, t_in=10, latency=3, data=0xAB.
REQ-035 in_fire and out_fire together at cycle 5, FIFO empty -> at 6: latency=0, t_in=5; FIFO stays empty; no underflow.
REQ-036 17 in_fire with DEPTH=16, no out_fire -> overflow=1 after the 17th; the 16 out_fires that follow return ids 0..15, and the next out_fire sets underflow.
REQ-037 trace_ready=0 and two out_fires -> first record held stable, drop_cnt=1; raise trace_ready -> first record accepted.
REQ-038 cycle_cnt preset near wrap: in_fire at 0xFFFFFFFE, out_fire 4 cycles later -> latency=4.
REQ-039 rst_n pulsed low with 3 entries in flight and trace_valid=1 -> all outputs 0; the next in_fire/out_fire pair yields id=0 with no underflow.
